vector_axpy_streamer: RTL and testbench
=======================================

Name: vector_axpy_streamer

Overview:
Sequential inverse of the vector-to-scalar reduction. It accepts one scalar a and two M31 vectors x and b in a single valid/ready transfer, then streams y[i] = (a*x[i] + b[i]) mod p, with p = 2^31-1, one element per handshake in index order. It sits between the vector register file and element-serial consumers such as the NTT/hash feeders. It uses one shared multiply-reduce and add-reduce datapath.

Parameters:
WORD_WIDTH, 31, element width in bits; the block is only specified for 31 (M31 field).
VECTOR_SIZE, 16, elements per vector; must be >= 1.
IDX_W, (VECTOR_SIZE>1 ? $clog2(VECTOR_SIZE) : 1), width of the element index.

Ports:
clk  input  1  clock; all state is updated on the rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  the input job (in_scalar, in_vec_x, in_vec_b) is valid.
in_ready  output  1  the block can accept a job; high only in IDLE.
in_scalar  input  WORD_WIDTH  scalar a.
in_vec_x  input  WORD_WIDTH x [0:VECTOR_SIZE-1]  vector x.
in_vec_b  input  WORD_WIDTH x [0:VECTOR_SIZE-1]  vector b.
out_valid  output  1  out_elem, out_index and out_last are valid.
out_ready  input  1  downstream accepts the current element.
out_elem  output  WORD_WIDTH  y[out_index], canonical in [0, p-1].
out_index  output  IDX_W  index of the current element.
out_last  output  1  high with out_valid when out_index == VECTOR_SIZE-1.
busy  output  1  high in RUN.

Behaviour:
- Reset is asynchronous and active-high; it is applied immediately and does not wait for a clock edge.
  - While reset is asserted: state = IDLE, index = 0, out_valid = 0, out_last = 0, out_index = 0, out_elem = 0, busy = 0, in_ready = 1, and captured registers = 0.
  - Any in_valid seen while reset is asserted is ignored.
  - Reset asserted mid-stream aborts the job. Remaining elements are never emitted, and there is no partial output after reset is released.
- FSM has two states, IDLE and RUN.
  - IDLE: in_ready = 1. On an edge with in_valid = 1, capture in_scalar, in_vec_x and in_vec_b into registers, set index = 0, and go to RUN.
  - RUN: in_ready = 0 and out_valid = 1. On an edge with out_ready = 1:
    - if index == VECTOR_SIZE-1, go to IDLE;
    - otherwise index = index + 1.
- Timing:
  - Accept at edge N gives out_valid = 1 from cycle N+1, carrying element 0.
  - With out_ready held high, one element is emitted per cycle, so a job occupies VECTOR_SIZE cycles in RUN.
  - After the last handshake, in_ready = 1 in the following cycle. There is no overlap between consecutive jobs.
- Backpressure: while out_valid = 1 and out_ready = 0, out_elem, out_index and out_last are held stable. Input ports may change freely after acceptance; only the captured registers are used.
- Outputs are gated: when out_valid = 0, out_elem = 0, out_index = 0 and out_last = 0.
- Arithmetic:
  - Treat any input word equal to 2^31-1 as 0.
  - prod = (a*x[i]) mod p, computed from the full 62-bit product. Reduce with the fold (lo31 + hi31), then one conditional subtract of p.
  - sum = (prod + b[i]) mod p, computed from the 32-bit sum. Fold, then conditional subtract.
  - out_elem is always < p. The value 2^31-1 is never emitted.
- The datapath from captured registers to out_elem may be combinational, indexed by index. No multicycle paths are allowed; it must close timing in one cycle.
- VECTOR_SIZE = 1: out_last = 1 on the only element, and the FSM returns to IDLE after one handshake.
- in_valid and in_ready are only evaluated in IDLE. A job presented during RUN waits; it is neither dropped nor accepted.

Test Plan:
1. VECTOR_SIZE=4, a=2, x={3,5,7,9}, b={4,0,1,p-1}, out_ready=1 -> out_elem {10,10,15,17}, out_index 0..3, out_last only on index 3, in_ready=1 the cycle after.
2. a=p-1, x[0]=1, b[0]=0 -> p-1. a=2^30, x[0]=2, b[0]=0 -> 1. a=1, x[0]=1, b[0]=p-1 -> 0.
3. a=2^31-1 (non-canonical zero), any x, b={5,...} -> out_elem equals b element-wise; x[i]=b[i]=2^31-1 -> 0.
4. Backpressure: drop out_ready for 3 cycles on index 1 -> out_elem and out_index held stable, no element skipped or duplicated; total elements = VECTOR_SIZE.
5. Assert reset asynchronously (mid-cycle) at index 2 -> out_valid, busy and out_index drop to 0 immediately without a clock edge. After release, in_ready=1 and a new job streams from index 0.
6. in_valid held high across two back-to-back jobs -> second job accepted only after the first's last handshake. Random a, x, b over 1000 jobs match a reference model of (a*x+b) mod p.

Source files
------------

// File: rtl/vector_axpy_streamer.sv
// Purpose: capture scalar a and M31 vectors x, b in one transfer, then stream
//          y[i] = (a*x[i] + b[i]) mod (2^31-1) one element per handshake, index order.
// Latency: accept at edge N -> element 0 valid in cycle N+1; one element/cycle with out_ready high.
// Backpressure: out_ready low holds out_elem/out_index/out_last stable; in_ready low while streaming.
// Ports: clk, reset (async, active-high); in_valid/in_ready + in_scalar/in_vec_x/in_vec_b job input;
//        out_valid/out_ready + out_elem/out_index/out_last element stream; busy = streaming.
module vector_axpy_streamer #(
  parameter int WORD_WIDTH  = 31,
  parameter int VECTOR_SIZE = 16,
  parameter int IDX_W       = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_scalar,
  input  logic [WORD_WIDTH-1:0] in_vec_x [0:VECTOR_SIZE-1],
  input  logic [WORD_WIDTH-1:0] in_vec_b [0:VECTOR_SIZE-1],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_elem,
  output logic [IDX_W-1:0]      out_index,
  output logic                  out_last,
  output logic                  busy
);

  localparam logic [WORD_WIDTH-1:0] P        = {WORD_WIDTH{1'b1}};
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(VECTOR_SIZE - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [IDX_W-1:0]      index;
  logic [WORD_WIDTH-1:0] a_q;
  logic [WORD_WIDTH-1:0] x_q [0:VECTOR_SIZE-1];
  logic [WORD_WIDTH-1:0] b_q [0:VECTOR_SIZE-1];

  // Single conditional subtract: callers guarantee v < 2p, so the result is canonical.
  function automatic logic [WORD_WIDTH-1:0] csub(input logic [WORD_WIDTH:0] v);
    logic [WORD_WIDTH:0] d;
    d = v - {1'b0, P};
    return (v >= {1'b0, P}) ? d[WORD_WIDTH-1:0] : v[WORD_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      index <= '0;
      a_q   <= '0;
      for (int i = 0; i < VECTOR_SIZE; i++) begin
        x_q[i] <= '0;
        b_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_scalar;
            for (int i = 0; i < VECTOR_SIZE; i++) begin
              x_q[i] <= in_vec_x[i];
              b_q[i] <= in_vec_b[i];
            end
            index <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            if (index == LAST_IDX) begin
              state <= IDLE;
            end else begin
              index <= index + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shared single-cycle datapath on the element selected by index.
  logic [WORD_WIDTH-1:0]   a_c, x_c, b_c, prod, y;
  logic [2*WORD_WIDTH-1:0] prod_full;
  logic [WORD_WIDTH:0]     prod_fold, sum_raw, sum_fold;

  always_comb begin
    // The all-ones word is a non-canonical encoding of zero.
    a_c       = (a_q == P) ? '0 : a_q;
    x_c       = (x_q[index] == P) ? '0 : x_q[index];
    b_c       = (b_q[index] == P) ? '0 : b_q[index];
    prod_full = (2*WORD_WIDTH)'(a_c) * (2*WORD_WIDTH)'(x_c);
    // 2^31 == 1 mod p, so the high half folds straight onto the low half.
    prod_fold = {1'b0, prod_full[WORD_WIDTH-1:0]} + {1'b0, prod_full[2*WORD_WIDTH-1:WORD_WIDTH]};
    prod      = csub(prod_fold);
    sum_raw   = {1'b0, prod} + {1'b0, b_c};
    sum_fold  = {1'b0, sum_raw[WORD_WIDTH-1:0]} + (WORD_WIDTH+1)'(sum_raw[WORD_WIDTH]);
    y         = csub(sum_fold);
  end

  // Status decodes straight from the state flop so reset clears them asynchronously.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == RUN);
  assign out_elem  = out_valid ? y : '0;
  assign out_index = out_valid ? index : '0;
  assign out_last  = out_valid && (index == LAST_IDX);

endmodule

// File: tb/tb_vector_axpy_streamer.sv
module tb_vector_axpy_streamer;
  localparam int VS = 4;
  localparam logic [30:0] P = 31'h7FFFFFFF;

  typedef logic [30:0] vec_t [0:VS-1];
  typedef struct packed {
    logic [30:0] elem;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [30:0] in_scalar = '0;
  vec_t        in_vec_x;
  vec_t        in_vec_b;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [30:0] out_elem;
  logic [1:0]  out_index;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  vector_axpy_streamer #(.WORD_WIDTH(31), .VECTOR_SIZE(VS)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_scalar(in_scalar), .in_vec_x(in_vec_x), .in_vec_b(in_vec_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_elem(out_elem),
    .out_index(out_index), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: plain modular arithmetic on 64-bit values.
  function automatic logic [30:0] model(input logic [30:0] a, input logic [30:0] x, input logic [30:0] b);
    logic [63:0] aa, xx, bb, r;
    aa = (a == P) ? 64'd0 : {33'd0, a};
    xx = (x == P) ? 64'd0 : {33'd0, x};
    bb = (b == P) ? 64'd0 : {33'd0, b};
    r  = ((aa * xx) % 64'h7FFFFFFF + bb) % 64'h7FFFFFFF;
    return r[30:0];
  endfunction

  function automatic logic [30:0] rand_word();
    int unsigned r;
    r = $urandom_range(0, 7);
    if (r == 0) return P;
    if (r == 1) return P - 31'd1;
    return 31'($urandom);
  endfunction

  task automatic rand_inputs();
    in_scalar = rand_word();
    for (int i = 0; i < VS; i++) begin
      in_vec_x[i] = rand_word();
      in_vec_b[i] = rand_word();
    end
  endtask

  // Expected elements for the job currently on the input ports.
  task automatic push_job();
    exp_t e;
    for (int i = 0; i < VS; i++) begin
      e.elem = model(in_scalar, in_vec_x[i], in_vec_b[i]);
      e.idx  = 2'(i);
      e.last = (i == VS - 1);
      sb.push_back(e);
    end
  endtask

  // Present a job, wait for acceptance, then scramble the input ports.
  task automatic accept_job(input logic [30:0] a, input vec_t x, input vec_t b);
    @(negedge clk);
    in_scalar = a; in_vec_x = x; in_vec_b = b; in_valid = 1'b1;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b want 1", in_ready);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      push_job();
      in_valid = 1'b0;
      rand_inputs();
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    rand_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, out_last} !== 4'b1000 || out_elem !== 31'd0 || out_index !== 2'd0) begin
      errors++;
      $display("FAIL reset_state rdy/vld/busy/last=%b%b%b%b elem=%h idx=%0d want 1000 0 0",
               in_ready, out_valid, busy, out_last, out_elem, out_index);
    end
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ignores_valid in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_basic();
    vec_t x, b;
    logic [30:0] want [0:VS-1];
    exp_t e;
    x = '{31'd3, 31'd5, 31'd7, 31'd9};
    b = '{31'd4, 31'd0, 31'd1, P - 31'd1};
    want = '{31'd10, 31'd10, 31'd15, 31'd17};
    out_ready = 1'b1;
    accept_job(31'd2, x, b);
    for (int n = 0; n < VS; n++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL basic_run_flags n=%0d vld=%b busy=%b rdy=%b want 1 1 0", n, out_valid, busy, in_ready);
      end
      checks++;
      if (out_elem !== want[n] || out_index !== 2'(n) || out_last !== (n == VS - 1)) begin
        errors++;
        $display("FAIL basic_elem n=%0d got %0d idx %0d last %b want %0d idx %0d last %b",
                 n, out_elem, out_index, out_last, want[n], n, (n == VS - 1));
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_elem !== e.elem) begin
          errors++;
          $display("FAIL basic_model n=%0d got %0d want %0d", n, out_elem, e.elem);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_elem !== 31'd0 ||
        out_index !== 2'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL basic_idle_after rdy=%b vld=%b busy=%b elem=%h idx=%0d last=%b want 1 0 0 0 0 0",
               in_ready, out_valid, busy, out_elem, out_index, out_last);
    end
  endtask

  // Element 0 of each job is checked against a hand-computed value,
  // the rest against the reference model.
  task automatic test_corner();
    logic [30:0] av [0:4];
    logic [30:0] x0 [0:4];
    logic [30:0] b0 [0:4];
    logic [30:0] w0 [0:4];
    vec_t x, b;
    exp_t e;
    int n;
    av = '{P - 31'd1, 31'h40000000, 31'd1, P,     31'd12345};
    x0 = '{31'd1,     31'd2,        31'd1, 31'd7, P};
    b0 = '{31'd0,     31'd0,        P - 31'd1, 31'd5, P};
    w0 = '{P - 31'd1, 31'd1,        31'd0, 31'd5, 31'd0};
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < VS; i++) begin
        x[i] = rand_word();
        b[i] = rand_word();
      end
      x[0] = x0[k]; b[0] = b0[k];
      if (k == 3) b = '{31'd5, 31'd6, 31'd7, 31'd8};
      if (k == 4) begin
        x = '{P, P, P, P};
        b = '{P, P, P, P};
      end
      accept_job(av[k], x, b);
      n = 0;
      for (int c = 0; c < 12 && n < VS; c++) begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL corner_extra k=%0d idx=%0d", k, out_index);
          end else begin
            e = sb.pop_front();
            if ({out_elem, out_index, out_last} !== e) begin
              errors++;
              $display("FAIL corner_elem k=%0d got %0d/%0d/%b want %0d/%0d/%b",
                       k, out_elem, out_index, out_last, e.elem, e.idx, e.last);
            end
          end
          if (n == 0) begin
            checks++;
            if (out_elem !== w0[k]) begin
              errors++;
              $display("FAIL corner_const k=%0d got %0d want %0d", k, out_elem, w0[k]);
            end
          end
          if (k == 3) begin
            checks++;
            if (out_elem !== b[n]) begin
              errors++;
              $display("FAIL noncanon_a n=%0d got %0d want %0d", n, out_elem, b[n]);
            end
          end
          n++;
        end
      end
      checks++;
      if (n != VS) begin
        errors++;
        $display("FAIL corner_count k=%0d got %0d want %0d", k, n, VS);
      end
    end
  endtask

  task automatic test_backpressure();
    vec_t x, b;
    exp_t e;
    int n, stalls;
    logic [30:0] held_elem;
    logic [1:0]  held_idx;
    for (int i = 0; i < VS; i++) begin
      x[i] = rand_word();
      b[i] = rand_word();
    end
    out_ready = 1'b1;
    accept_job(rand_word(), x, b);
    n = 0; stalls = 0; held_elem = '0; held_idx = '0;
    for (int c = 0; c < 30 && n < VS; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 2'd1 && stalls < 3) begin
        out_ready = 1'b0;
        if (stalls == 0) begin
          held_elem = out_elem; held_idx = out_index;
        end else begin
          checks++;
          if (out_elem !== held_elem || out_index !== held_idx || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold got %0d/%0d/%b want %0d/%0d/1",
                     out_elem, out_index, out_valid, held_elem, held_idx);
          end
        end
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL bp_extra idx=%0d", out_index);
        end else begin
          e = sb.pop_front();
          if ({out_elem, out_index, out_last} !== e) begin
            errors++;
            $display("FAIL bp_elem got %0d/%0d/%b want %0d/%0d/%b",
                     out_elem, out_index, out_last, e.elem, e.idx, e.last);
          end
        end
        n++;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (n != VS || stalls != 3 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_count elems=%0d stalls=%0d vld=%b want %0d 3 0", n, stalls, out_valid, VS);
    end
  endtask

  task automatic test_async_reset();
    vec_t x, b;
    exp_t e;
    int n;
    logic found;
    for (int i = 0; i < VS; i++) begin
      x[i] = rand_word();
      b[i] = rand_word();
    end
    out_ready = 1'b1;
    accept_job(rand_word(), x, b);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_index == 2'd2) found = 1'b1;
      else if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({out_elem, out_index, out_last} !== e) begin
          errors++;
          $display("FAIL arst_pre got %0d/%0d want %0d/%0d", out_elem, out_index, e.elem, e.idx);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL arst_reach_idx2 found=%b want 1", found);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 2'd0 || in_ready !== 1'b1 ||
        out_elem !== 31'd0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL arst_immediate vld=%b busy=%b idx=%0d rdy=%b elem=%h last=%b want 0 0 0 1 0 0",
               out_valid, busy, out_index, in_ready, out_elem, out_last);
    end
    sb.delete();
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL arst_release vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    for (int i = 0; i < VS; i++) begin
      x[i] = rand_word();
      b[i] = rand_word();
    end
    accept_job(rand_word(), x, b);
    n = 0;
    for (int c = 0; c < 12 && n < VS; c++) begin
      @(negedge clk);
      if (out_valid && out_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({out_elem, out_index, out_last} !== e) begin
          errors++;
          $display("FAIL arst_new_job got %0d/%0d/%b want %0d/%0d/%b",
                   out_elem, out_index, out_last, e.elem, e.idx, e.last);
        end
        n++;
      end
    end
    checks++;
    if (n != VS) begin
      errors++;
      $display("FAIL arst_new_count got %0d want %0d", n, VS);
    end
  endtask

  // in_valid stays high; random jobs and random out_ready throttling.
  task automatic test_back_to_back();
    int accepted, cyc;
    logic accept, last_hs;
    exp_t e;
    accepted = 0; cyc = 0; last_hs = 1'b0;
    rand_inputs();
    in_valid = 1'b1;
    out_ready = 1'b1;
    while ((accepted < 1000 || sb.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (last_hs) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++;
          $display("FAIL b2b_ready_after_last rdy=%b want 1", in_ready);
        end
      end
      if (in_ready) begin
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
          errors++;
          $display("FAIL b2b_overlap pending=%0d vld=%b want 0 0", sb.size(), out_valid);
        end
      end
      last_hs = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra idx=%0d elem=%0d", out_index, out_elem);
        end else begin
          e = sb.pop_front();
          if ({out_elem, out_index, out_last} !== e) begin
            errors++;
            $display("FAIL b2b_elem got %0d/%0d/%b want %0d/%0d/%b",
                     out_elem, out_index, out_last, e.elem, e.idx, e.last);
          end
          last_hs = out_last;
        end
      end
      accept = in_ready && in_valid;
      @(posedge clk); #1;
      if (accept) begin
        push_job();
        accepted++;
        if (accepted < 1000) rand_inputs();
        else in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (accepted != 1000 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_timeout accepted=%0d pending=%0d want 1000 0", accepted, sb.size());
    end
  endtask

  initial begin
    for (int i = 0; i < VS; i++) begin
      in_vec_x[i] = '0;
      in_vec_b[i] = '0;
    end
    test_reset();
    test_basic();
    test_corner();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
